bin_to_bcd_seq: RTL

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_digit_adj3.sv | 11 +
 rtl/bin_to_bcd_seq.sv | 88 ++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the sequential binary-to-BCD converter
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } bcd_state_t;

  localparam int BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESHOLD = 4'd5;

  // ceil(width * log10(2)); width*log10(2) is never an integer, so this cannot round short
  function automatic int bcd_digits(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_digit_adj3.sv
// rtl/bcd_digit_adj3.sv - double-dabble digit correction: add 3 when the digit is 5 or more
module bcd_digit_adj3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  assign dout = (din >= ADD3_THRESHOLD) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - one-bit-per-cycle shift-and-add-3 binary to packed BCD converter
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = bcd_digits(WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          bin_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  bcd_state_t        state;
  logic [BCD_W-1:0]  scratch;
  logic [BCD_W-1:0]  scratch_adj;
  logic [BCD_W-1:0]  scratch_next;
  logic [WIDTH-1:0]  bin_sr;
  logic [CNT_W-1:0]  cnt;
  logic              unused_adj_msb;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj3 u_adj3 (
      .din  (scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (scratch_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // With DIGITS sized for WIDTH the adjusted top bit is always 0, so nothing is lost here
  assign scratch_next   = {scratch_adj[BCD_W-2:0], bin_sr[WIDTH-1]};
  assign unused_adj_msb = scratch_adj[BCD_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      bcd_out   <= '0;
      scratch   <= '0;
      bin_sr    <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            bin_sr   <= bin_in;
            scratch  <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          scratch <= scratch_next;
          bin_sr  <= {bin_sr[WIDTH-2:0], 1'b0};
          cnt     <= cnt + 1'b1;
          // The last shift lands straight in bcd_out so the result appears on the WIDTH-th edge
          if (cnt == LAST_ITER) begin
            bcd_out   <= scratch_next;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
